// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction opcode field and fetch-sequencer state encoding.
package cpu_pkg;

  localparam int unsigned OPC_LSB = 6;
  localparam int unsigned OPC_MSB = 8;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_FIN   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_unit_if.sv
// Program-load, start and core-handshake signals between a host/core and the fetch unit.
interface cpu_fetch_unit_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
);
  logic              iWe;
  logic [ADDR_W-1:0] iWaddr;
  logic [DATA_W-1:0] iWdata;
  logic [ADDR_W:0]   iLen;
  logic              iStart;
  logic              iDone;
  logic [DATA_W-1:0] oDin;
  logic              oRun;
  logic [ADDR_W-1:0] oPc;
  logic              oBusy;
  logic              oEnd;
  logic              oErr;

  modport master (
    output iWe, iWaddr, iWdata, iLen, iStart, iDone,
    input  oDin, oRun, oPc, oBusy, oEnd, oErr
  );

  modport slave (
    input  iWe, iWaddr, iWdata, iLen, iStart, iDone,
    output oDin, oRun, oPc, oBusy, oEnd, oErr
  );
endinterface

// File: rtl/cpu_prog_ram.sv
// Program RAM: synchronous write, asynchronous read, contents not reset.
module cpu_prog_ram #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction-fetch sequencer: feeds program words and mvi immediates to the core's DIN/Run,
// advancing on Done, with a timeout abort while waiting.
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 16,
  parameter logic [2:0]  IMM_OP  = OP_MVI,
  parameter int unsigned TIMEOUT = 64
) (
  input logic             iClk,
  input logic             iRst,
  cpu_fetch_unit_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              run_q, run_d;
  logic              end_q, end_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rd_data;
  logic              ram_we;

  assign ram_we = bus.iWe && (state_q == S_IDLE);

  // Read port addresses the word that will be presented next cycle, so oDin can be registered.
  cpu_prog_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (iClk),
    .we    (ram_we),
    .waddr (bus.iWaddr),
    .wdata (bus.iWdata),
    .raddr (pc_d),
    .rdata (rd_data)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wait_d  = '0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          err_d = 1'b0;
          len_d = bus.iLen;
          cnt_d = '0;
          if (bus.iLen == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_ISSUE;
            pc_d    = '0;
          end
        end
      end
      S_ISSUE: begin
        pc_d    = pc_q + ADDR_W'(1);
        cnt_d   = cnt_q + (ADDR_W + 1)'(1);
        // din_q holds mem[pc_q] throughout ISSUE since RAM writes are blocked while busy.
        state_d = (din_q[OPC_MSB:OPC_LSB] == IMM_OP) ? S_IMM : S_WAIT;
      end
      S_IMM: begin
        pc_d    = pc_q + ADDR_W'(1);
        cnt_d   = cnt_q + (ADDR_W + 1)'(1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.iDone) begin
          state_d = (cnt_q >= len_q) ? S_FIN : S_ISSUE;
        end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    run_d  = (state_d == S_ISSUE) || (state_d == S_IMM);
    din_d  = run_d ? rd_data : '0;
    end_d  = (state_d == S_FIN);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      din_q   <= din_d;
      run_q   <= run_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.oDin  = din_q;
  assign bus.oRun  = run_q;
  assign bus.oPc   = pc_q;
  assign bus.oBusy = busy_q;
  assign bus.oEnd  = end_q;
  assign bus.oErr  = err_q;

endmodule
